// File: rtl/sop_lut_eval.sv
// Programmable N-input sum-of-minterms function with an eval port and a self-driven exhaustive sweep.
// Optional SOP_LUT_ONES_COUNT_EN adds ones_cnt, the count of true results in the current/last sweep.
module sop_lut_eval #(
    parameter int N_IN = 3,
    parameter logic [(1<<N_IN)-1:0] DEFAULT_MASK = 8'hCA
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cfg_we,
    input  logic [(1<<N_IN)-1:0]   cfg_mask,
    input  logic                   start,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N_IN-1:0]        in_vec,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [N_IN-1:0]        out_vec,
    output logic                   out_s,
    output logic                   busy,
    output logic                   sweep_done
`ifdef SOP_LUT_ONES_COUNT_EN
    ,
    output logic [N_IN:0]          ones_cnt
`endif
);

    localparam int MW = 1 << N_IN;
    localparam logic [N_IN:0] CNT_ONE = 1;

    typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DONE} state_t;

    state_t          state;
    logic [MW-1:0]   mask;
    logic [N_IN:0]   cnt;
    logic            out_free;
    logic            xfer;
    logic            accept;

`ifdef SOP_LUT_ONES_COUNT_EN
    // Distinguishes sweep results from an eval result still draining after start.
    logic            out_sweep;
`endif

    assign out_free   = !out_valid || out_ready;
    assign xfer       = out_valid && out_ready;
    assign in_ready   = (state == S_IDLE) && !start && out_free;
    assign accept     = in_valid && in_ready;
    assign busy       = (state != S_IDLE);
    assign sweep_done = (state == S_DONE);

    // cnt's top bit set means every vector has been loaded; only the last result remains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            mask      <= DEFAULT_MASK;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_vec   <= '0;
            out_s     <= 1'b0;
`ifdef SOP_LUT_ONES_COUNT_EN
            out_sweep <= 1'b0;
            ones_cnt  <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (cfg_we) begin
                        mask <= cfg_mask;
                    end
                    if (start) begin
                        state <= S_SWEEP;
                        cnt   <= '0;
`ifdef SOP_LUT_ONES_COUNT_EN
                        ones_cnt <= '0;
`endif
                        if (xfer) begin
                            out_valid <= 1'b0;
                        end
                    end else if (accept) begin
                        out_vec   <= in_vec;
                        out_s     <= mask[in_vec];
                        out_valid <= 1'b1;
`ifdef SOP_LUT_ONES_COUNT_EN
                        out_sweep <= 1'b0;
`endif
                    end else if (xfer) begin
                        out_valid <= 1'b0;
                    end
                end
                S_SWEEP: begin
                    if (out_free && !cnt[N_IN]) begin
                        out_vec   <= cnt[N_IN-1:0];
                        out_s     <= mask[cnt[N_IN-1:0]];
                        out_valid <= 1'b1;
                        cnt       <= cnt + CNT_ONE;
`ifdef SOP_LUT_ONES_COUNT_EN
                        out_sweep <= 1'b1;
`endif
                    end else if (xfer) begin
                        out_valid <= 1'b0;
                        if (cnt[N_IN]) begin
                            state <= S_DONE;
                        end
                    end
`ifdef SOP_LUT_ONES_COUNT_EN
                    if (xfer && out_s && out_sweep) begin
                        ones_cnt <= ones_cnt + CNT_ONE;
                    end
`endif
                end
                S_DONE: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sop_lut_eval.sv
// Directed self-checking bench for sop_lut_eval (N_IN=3, default mask 8'hCA).
// Define SOP_LUT_ONES_COUNT_EN to also check ones_cnt.
module tb_sop_lut_eval;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cfg_we;
    logic [7:0] cfg_mask;
    logic       start;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_vec;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_vec;
    logic       out_s;
    logic       busy;
    logic       sweep_done;
`ifdef SOP_LUT_ONES_COUNT_EN
    logic [3:0] ones_cnt;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sop_lut_eval dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_we     (cfg_we),
        .cfg_mask   (cfg_mask),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_vec     (in_vec),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_vec    (out_vec),
        .out_s      (out_s),
        .busy       (busy),
        .sweep_done (sweep_done)
`ifdef SOP_LUT_ONES_COUNT_EN
        ,
        .ones_cnt   (ones_cnt)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic st, input logic iv, input logic [2:0] vec,
                                 input logic ordy, input logic we, input logic [7:0] m);
        start     = st;
        in_valid  = iv;
        in_vec    = vec;
        out_ready = ordy;
        cfg_we    = we;
        cfg_mask  = m;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Follows a running sweep, checking order, values and hold-under-stall, until sweep_done.
    task automatic watchSweep(input logic [7:0] exp_mask, input logic [15:0] rdy_pat,
                              input int start_hold, input int we_cycle);
        int n = 0;
        int dones = 0;
        logic held = 1'b0;
        logic [2:0] held_vec = '0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            applyStimulus(cyc < start_hold, 1'b0, 3'd0, rdy_pat[cyc % 16], cyc == we_cycle, 8'h00);
            #1;
            if (held) checkOutput("sweep_hold_vec", {29'd0, out_vec}, {29'd0, held_vec});
            if (sweep_done) begin
                dones++;
                break;
            end
            if (out_valid && out_ready) begin
                checkOutput("sweep_vec", {29'd0, out_vec}, n);
                if (n < 8) checkOutput("sweep_s", {31'd0, out_s}, {31'd0, exp_mask[n]});
                n++;
            end
            held     = out_valid && !out_ready;
            held_vec = out_vec;
            step();
        end
        checkOutput("sweep_count", n, 8);
        checkOutput("sweep_done_seen", dones, 1);
        applyStimulus(1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 8'h00);
        step();
        checkOutput("sweep_done_pulse", {31'd0, sweep_done}, 0);
        checkOutput("sweep_busy_end", {31'd0, busy}, 0);
    endtask

    initial begin
        logic [7:0] ca = 8'hCA;

        $display("[TB] sop_lut_eval directed test");
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 8'h00);
        step();
        step();
        checkOutput("rst_out_valid", {31'd0, out_valid}, 0);
        checkOutput("rst_out_vec", {29'd0, out_vec}, 0);
        checkOutput("rst_out_s", {31'd0, out_s}, 0);
        checkOutput("rst_busy", {31'd0, busy}, 0);
        checkOutput("rst_sweep_done", {31'd0, sweep_done}, 0);
        checkOutput("rst_in_ready", {31'd0, in_ready}, 1);
        rst_n = 1'b1;
        step();

        // Unstalled sweep: results on consecutive cycles, first one two edges after start.
        applyStimulus(1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 8'h00);
        step();
        applyStimulus(1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 8'h00);
        #1;
        checkOutput("sw1_busy", {31'd0, busy}, 1);
        checkOutput("sw1_no_out_yet", {31'd0, out_valid}, 0);
        for (int k = 0; k < 8; k++) begin
            step();
            checkOutput("sw1_valid", {31'd0, out_valid}, 1);
            checkOutput("sw1_vec", {29'd0, out_vec}, k);
            checkOutput("sw1_s", {31'd0, out_s}, {31'd0, ca[k]});
            checkOutput("sw1_in_ready", {31'd0, in_ready}, 0);
        end
        step();
        checkOutput("sw1_done", {31'd0, sweep_done}, 1);
        checkOutput("sw1_done_valid", {31'd0, out_valid}, 0);
        step();
        checkOutput("sw1_done_once", {31'd0, sweep_done}, 0);
        checkOutput("sw1_idle", {31'd0, busy}, 0);
`ifdef SOP_LUT_ONES_COUNT_EN
        checkOutput("sw1_ones_cnt", {28'd0, ones_cnt}, 4);
`endif

        // Eval with backpressure.
        applyStimulus(1'b0, 1'b1, 3'b110, 1'b0, 1'b0, 8'h00);
        #1;
        checkOutput("ev_in_ready", {31'd0, in_ready}, 1);
        step();
        checkOutput("ev_valid", {31'd0, out_valid}, 1);
        checkOutput("ev_vec", {29'd0, out_vec}, 6);
        checkOutput("ev_s", {31'd0, out_s}, 1);
        applyStimulus(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 8'h00);
        for (int k = 0; k < 3; k++) begin
            #1;
            checkOutput("ev_bp_in_ready", {31'd0, in_ready}, 0);
            step();
            checkOutput("ev_bp_valid", {31'd0, out_valid}, 1);
            checkOutput("ev_bp_vec", {29'd0, out_vec}, 6);
            checkOutput("ev_bp_s", {31'd0, out_s}, 1);
        end
        applyStimulus(1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 8'h00);
        #1;
        checkOutput("ev_release_in_ready", {31'd0, in_ready}, 1);
        step();
        checkOutput("ev_drained", {31'd0, out_valid}, 0);
        checkOutput("ev_ready_back", {31'd0, in_ready}, 1);

        // Mask reload in the same cycle as an accept: that vector sees the old mask.
        applyStimulus(1'b0, 1'b1, 3'b001, 1'b1, 1'b1, 8'h81);
        step();
        checkOutput("ml_old_mask", {31'd0, out_s}, 1);
        applyStimulus(1'b0, 1'b1, 3'b001, 1'b1, 1'b0, 8'h00);
        step();
        checkOutput("ml_new_mask_1", {31'd0, out_s}, 0);
        applyStimulus(1'b0, 1'b1, 3'b111, 1'b1, 1'b0, 8'h00);
        step();
        checkOutput("ml_new_mask_7", {31'd0, out_s}, 1);
        applyStimulus(1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 8'h00);
        step();
        checkOutput("ml_drained", {31'd0, out_valid}, 0);

        // Stalled sweep with mask 8'h81 and a cfg_we=8'h00 attempt mid-sweep.
        applyStimulus(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 8'h00);
        step();
        watchSweep(8'h81, 16'b0110_1001_1010_1101, 0, 5);
`ifdef SOP_LUT_ONES_COUNT_EN
        checkOutput("sw2_ones_cnt", {28'd0, ones_cnt}, 2);
`endif
        applyStimulus(1'b0, 1'b1, 3'b000, 1'b1, 1'b0, 8'h00);
        step();
        checkOutput("sw2_mask_kept", {31'd0, out_s}, 1);
        applyStimulus(1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 8'h00);
        step();

        // Reset mid-sweep once vector 4 has transferred.
        applyStimulus(1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 8'h00);
        step();
        applyStimulus(1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 8'h00);
        for (int k = 0; k < 6; k++) step();
        checkOutput("mr_pre_vec", {29'd0, out_vec}, 5);
        rst_n = 1'b0;
        #1;
        checkOutput("mr_valid", {31'd0, out_valid}, 0);
        checkOutput("mr_busy", {31'd0, busy}, 0);
        checkOutput("mr_done", {31'd0, sweep_done}, 0);
        step();
        step();
        checkOutput("mr_done_held", {31'd0, sweep_done}, 0);
        rst_n = 1'b1;
        step();
        checkOutput("mr_no_done", {31'd0, sweep_done}, 0);
        applyStimulus(1'b0, 1'b1, 3'b011, 1'b1, 1'b0, 8'h00);
        step();
        checkOutput("mr_mask_default", {31'd0, out_s}, 1);
        checkOutput("mr_eval_vec", {29'd0, out_vec}, 3);
        applyStimulus(1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 8'h00);
        step();

        // start held while busy: still exactly one sweep.
        applyStimulus(1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 8'h00);
        step();
        watchSweep(ca, 16'hFFFF, 4, -1);

        // start and in_valid together: start wins and the vector is not consumed.
        applyStimulus(1'b1, 1'b1, 3'b101, 1'b1, 1'b0, 8'h00);
        #1;
        checkOutput("si_in_ready", {31'd0, in_ready}, 0);
        step();
        checkOutput("si_no_accept", {31'd0, out_valid}, 0);
        checkOutput("si_busy", {31'd0, busy}, 1);
        watchSweep(ca, 16'hFFFF, 0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
